registro_ctrl: RTL and testbench
================================

// Module: registro_ctrl
// PURPOSE
//  Sequencer for the 4-bit universal shift register (registro_*). Accepts one command per
//  valid/ready handshake and drives MODO/DIR/ENB/D/S_IN for the required cycles.
//  Deserialises the register's S_OUT stream into RX_DATA and pulses DONE at completion.
//  Sits between the test/host logic and the register instance (struct, cond or synth).
// PARAMETERS
//  N   4  register width; sets the widths of D, CMD_DATA and RX_DATA
//  CW  4  shift-count width; CMD_CNT range 0..2^CW-1
// PORTS
//  CLK        in   1    clock; all logic on the rising edge
//  RESET      in   1    synchronous reset, active-high
//  CMD_VALID  in   1    command present
//  CMD_READY  out  1    controller idle; command accepted when VALID & READY at a CLK edge
//  CMD_OP     in   2    00 LOAD, 01 SHIFT, 10 ROTATE, 11 reserved (executed as NOP)
//  CMD_DIR    in   1    1 = left (S_OUT = Q[N-1]), 0 = right (S_OUT = Q[0])
//  CMD_CNT    in   CW   number of shift/rotate cycles
//  CMD_FILL   in   1    serial fill bit for SHIFT, driven on S_IN
//  CMD_DATA   in   N    parallel word for LOAD
//  S_OUT      in   1    serial output of the register
//  MODO       out  2    to register: 10 load, 00 shift, 01 rotate
//  DIR        out  1    to register
//  ENB        out  1    to register clock enable
//  D          out  N    to register parallel input
//  S_IN       out  1    to register serial input
//  RX_DATA    out  N    captured S_OUT bits, newest in the LSB
//  BUSY       out  1    high in EXEC and DONE
//  DONE       out  1    one-cycle completion pulse
// BEHAVIOUR
//  - FSM: IDLE -> EXEC -> DONE -> IDLE. State and all command fields are registered.
//    There is no combinational path from CMD_* to the register-side outputs.
//  - IDLE: CMD_READY=1, ENB=0. On accept, latch OP/DIR/CNT/FILL/DATA and clear RX_DATA to 0.
//    Go to EXEC, or go straight to DONE when (OP=SHIFT/ROTATE and CNT=0) or OP=11.
//  - EXEC, LOAD: ENB=1, MODO=10, D=latched DATA for exactly 1 cycle, then DONE.
//  - EXEC, SHIFT/ROTATE: ENB=1 for exactly CNT consecutive cycles.
//    MODO=00 (SHIFT) or 01 (ROTATE); DIR and S_IN are held at the latched values.
//    A down-counter is loaded with CNT and decremented on each ENB cycle; at 1, go to DONE.
//  - Capture: at each edge where ENB=1 in SHIFT/ROTATE, RX_DATA <= {RX_DATA[N-2:0], S_OUT}.
//    S_OUT is the pre-edge register output. If CNT > N, only the last N bits remain.
//  - DONE: DONE=1, BUSY=1, ENB=0 for one cycle, then IDLE. CMD_READY=0 in this cycle.
//  - Latency: accept at edge k; ENB high in cycles k+1..k+CNT; DONE in cycle k+CNT+1.
//    CMD_READY is high again in cycle k+CNT+2.
//  - Outside EXEC, MODO/DIR/D/S_IN hold their last driven values; only ENB gates the register.
//  - CMD_VALID while busy is ignored; the source must hold it until it sees READY.
//  - RESET (any state, including mid-EXEC): next state IDLE.
//    Outputs after reset: ENB=0, MODO=00, DIR=0, D=0, S_IN=0, RX_DATA=0, BUSY=0, DONE=0,
//    CMD_READY=1. The register contents are not restored.
// CONFIGURATION
//  - REGCTRL_ABORT_EN defined: adds input ABORT (1 bit) and output ABORTED (1 bit).
//    ABORT=1 in EXEC: ENB=0 in that same cycle and the next state is DONE.
//    ABORTED is set with that DONE pulse and cleared on the next accept or on RESET.
//    ABORT is ignored in IDLE and DONE.
//  - Undefined: neither port exists; every command runs to completion.
// TESTING
//  - Reset: assert RESET 2 cycles mid-SHIFT (CNT=8) -> next cycle IDLE, ENB=0, READY=1, RX_DATA=0.
//  - LOAD 4'b1011 -> ENB=1 with MODO=10, D=1011 for 1 cycle; DONE 2 cycles after accept.
//    Register Q=1011.
//  - After LOAD 1011: SHIFT DIR=1 CNT=4 FILL=0 -> ENB high 4 cycles.
//    Result RX_DATA=1011, Q=0000, DONE at k+5.
//  - After LOAD 1011: ROTATE DIR=0 CNT=4 -> RX_DATA=1101, Q=1011.
//  - SHIFT CNT=0 or OP=11 -> no ENB pulse, DONE in cycle k+1, RX_DATA=0.
//    Back-to-back VALID is accepted only when READY.
//  - REGCTRL_ABORT_EN: SHIFT CNT=10, ABORT in the 3rd EXEC cycle -> 2 ENB cycles only.
//    DONE=1 with ABORTED=1 in the next cycle.

Source files
------------

// File: rtl/registro_ctrl.sv
// Command sequencer for the 4-bit universal shift register: drives MODO/DIR/ENB/D/S_IN and
// deserialises S_OUT into RX_DATA. Optional abort support is enabled with REGCTRL_ABORT_EN.
module registro_ctrl #(
    parameter int N  = 4,
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [1:0]    i_cmd_op,
    input  logic          i_cmd_dir,
    input  logic [CW-1:0] i_cmd_cnt,
    input  logic          i_cmd_fill,
    input  logic [N-1:0]  i_cmd_data,
    input  logic          i_s_out,
`ifdef REGCTRL_ABORT_EN
    input  logic          i_abort,
    output logic          o_aborted,
`endif
    output logic [1:0]    o_modo,
    output logic          o_dir,
    output logic          o_enb,
    output logic [N-1:0]  o_d,
    output logic          o_s_in,
    output logic [N-1:0]  o_rx_data,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SHIFT  = 2'b01;
    localparam logic [1:0] OP_ROTATE = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    localparam logic [1:0] MODO_LOAD   = 2'b10;
    localparam logic [1:0] MODO_SHIFT  = 2'b00;
    localparam logic [1:0] MODO_ROTATE = 2'b01;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_op;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_modo;
    logic          r_dir;
    logic [N-1:0]  r_d;
    logic          r_s_in;
    logic [N-1:0]  r_rx;
    logic          w_enb;
    logic          w_accept;
`ifdef REGCTRL_ABORT_EN
    logic          w_abort;
    logic          r_aborted;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_enb    = 1'b0;
        w_accept = 1'b0;
`ifdef REGCTRL_ABORT_EN
        w_abort  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    w_accept = 1'b1;
                    // Zero-length shifts and reserved ops have nothing to drive
                    if ((i_cmd_op == OP_RSVD) ||
                        ((i_cmd_op != OP_LOAD) && (i_cmd_cnt == '0))) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
`ifdef REGCTRL_ABORT_EN
                w_abort = i_abort;
                if (i_abort) begin
                    w_next = S_DONE;
                end else begin
                    w_enb = 1'b1;
                    if ((r_op == OP_LOAD) || (r_cnt == CW'(1))) begin
                        w_next = S_DONE;
                    end
                end
`else
                w_enb = 1'b1;
                if ((r_op == OP_LOAD) || (r_cnt == CW'(1))) begin
                    w_next = S_DONE;
                end
`endif
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Register-side drive values only change on accept of a command that actually runs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op      <= OP_LOAD;
            r_cnt     <= '0;
            r_modo    <= 2'b00;
            r_dir     <= 1'b0;
            r_d       <= '0;
            r_s_in    <= 1'b0;
            r_rx      <= '0;
`ifdef REGCTRL_ABORT_EN
            r_aborted <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_op  <= i_cmd_op;
                r_cnt <= i_cmd_cnt;
                r_rx  <= '0;
`ifdef REGCTRL_ABORT_EN
                r_aborted <= 1'b0;
`endif
                if (i_cmd_op == OP_LOAD) begin
                    r_modo <= MODO_LOAD;
                    r_d    <= i_cmd_data;
                end else if ((i_cmd_op == OP_SHIFT) && (i_cmd_cnt != '0)) begin
                    r_modo <= MODO_SHIFT;
                    r_dir  <= i_cmd_dir;
                    r_s_in <= i_cmd_fill;
                end else if ((i_cmd_op == OP_ROTATE) && (i_cmd_cnt != '0)) begin
                    r_modo <= MODO_ROTATE;
                    r_dir  <= i_cmd_dir;
                    r_s_in <= i_cmd_fill;
                end
            end
            if (w_enb && (r_op != OP_LOAD)) begin
                r_cnt <= r_cnt - CW'(1);
                r_rx  <= {r_rx[N-2:0], i_s_out};
            end
`ifdef REGCTRL_ABORT_EN
            if (w_abort) begin
                r_aborted <= 1'b1;
            end
`endif
        end
    end

    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_enb       = w_enb;
    assign o_modo      = r_modo;
    assign o_dir       = r_dir;
    assign o_d         = r_d;
    assign o_s_in      = r_s_in;
    assign o_rx_data   = r_rx;
`ifdef REGCTRL_ABORT_EN
    assign o_aborted   = r_aborted;
`endif

endmodule

// File: tb/tb_registro_ctrl.sv
// Directed bench for registro_ctrl with a behavioural 4-bit universal shift register attached.
// Abort scenario is compiled in when REGCTRL_ABORT_EN is defined.
module tb_registro_ctrl;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_dir;
    logic [3:0] cmd_cnt;
    logic       cmd_fill;
    logic [3:0] cmd_data;
    logic       s_out;
    logic [1:0] modo;
    logic       dir;
    logic       enb;
    logic [3:0] d;
    logic       s_in;
    logic [3:0] rx_data;
    logic       busy;
    logic       done;
`ifdef REGCTRL_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] q;

    registro_ctrl #(.N(4), .CW(4)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_dir   (cmd_dir),
        .i_cmd_cnt   (cmd_cnt),
        .i_cmd_fill  (cmd_fill),
        .i_cmd_data  (cmd_data),
        .i_s_out     (s_out),
`ifdef REGCTRL_ABORT_EN
        .i_abort     (abort),
        .o_aborted   (aborted),
`endif
        .o_modo      (modo),
        .o_dir       (dir),
        .o_enb       (enb),
        .o_d         (d),
        .o_s_in      (s_in),
        .o_rx_data   (rx_data),
        .o_busy      (busy),
        .o_done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the shift register being sequenced
    always @(posedge clk) begin
        if (enb) begin
            case (modo)
                2'b10: q <= d;
                2'b00: q <= dir ? {q[2:0], s_in} : {s_in, q[3:1]};
                2'b01: q <= dir ? {q[2:0], q[3]} : {q[0], q[3:1]};
                default: q <= q;
            endcase
        end
    end
    assign s_out = dir ? q[3] : q[0];

    task automatic run_cmd(input logic [1:0] op, input logic cdir, input logic [3:0] cnt,
                           input logic fill, input logic [3:0] data,
                           output int enbs, output int done_cyc,
                           output logic [1:0] modo_seen, output logic [3:0] d_seen);
        @(negedge clk);
        cmd_op = op; cmd_dir = cdir; cmd_cnt = cnt; cmd_fill = fill; cmd_data = data;
        cmd_valid = 1'b1;
        for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        enbs = 0; done_cyc = -1; modo_seen = 2'bxx; d_seen = 4'bxxxx;
        for (int c = 1; c <= 40; c++) begin
            if (enb) begin
                if (enbs == 0) begin
                    modo_seen = modo;
                    d_seen = d;
                end
                enbs++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int e, dc; logic [1:0] m; logic [3:0] dd;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || enb !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ctrl ready=%b enb=%b busy=%b done=%b need 1 0 0 0", cmd_ready, enb, busy, done); end
        checks++; if (modo !== 2'b00 || dir !== 1'b0 || d !== 4'h0 || s_in !== 1'b0 || rx_data !== 4'h0) begin
            errors++; $display("[TB] FAIL reset_data modo=%b dir=%b d=%h s_in=%b rx=%h need 0", modo, dir, d, s_in, rx_data); end
        reset = 1'b0;
        run_cmd(2'b00, 1'b0, 4'd0, 1'b0, 4'b1011, e, dc, m, dd);
        @(negedge clk);
        cmd_op = 2'b01; cmd_dir = 1'b1; cmd_cnt = 4'd8; cmd_fill = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++; if (enb !== 1'b1 || busy !== 1'b1 || rx_data !== 4'b0001) begin
            errors++; $display("[TB] FAIL midshift enb=%b busy=%b rx=%b need 1 1 0001", enb, busy, rx_data); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || enb !== 1'b0 || busy !== 1'b0 || rx_data !== 4'h0) begin
            errors++; $display("[TB] FAIL midreset ready=%b enb=%b busy=%b rx=%b need 1 0 0 0000", cmd_ready, enb, busy, rx_data); end
        @(negedge clk);
        reset = 1'b0;
        checks++; if (modo !== 2'b00 || dir !== 1'b0 || d !== 4'h0 || s_in !== 1'b0 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_data modo=%b dir=%b d=%h s_in=%b done=%b need 0", modo, dir, d, s_in, done); end
    endtask

    task automatic test_load();
        int e, dc; logic [1:0] m; logic [3:0] dd;
        run_cmd(2'b00, 1'b0, 4'd0, 1'b0, 4'b1011, e, dc, m, dd);
        checks++; if (e !== 1 || dc !== 2) begin
            errors++; $display("[TB] FAIL load_timing enbs=%0d done_cyc=%0d need 1 2", e, dc); end
        checks++; if (m !== 2'b10 || dd !== 4'b1011) begin
            errors++; $display("[TB] FAIL load_drive modo=%b d=%b need 10 1011", m, dd); end
        checks++; if (q !== 4'b1011) begin
            errors++; $display("[TB] FAIL load_q q=%b need 1011", q); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL load_ready ready=%b busy=%b need 1 0", cmd_ready, busy); end
    endtask

    task automatic test_shift();
        int e, dc; logic [1:0] m; logic [3:0] dd;
        run_cmd(2'b00, 1'b0, 4'd0, 1'b0, 4'b1011, e, dc, m, dd);
        run_cmd(2'b01, 1'b1, 4'd4, 1'b0, 4'h0, e, dc, m, dd);
        checks++; if (e !== 4 || dc !== 5 || m !== 2'b00) begin
            errors++; $display("[TB] FAIL shift_timing enbs=%0d done_cyc=%0d modo=%b need 4 5 00", e, dc, m); end
        checks++; if (rx_data !== 4'b1011 || q !== 4'b0000) begin
            errors++; $display("[TB] FAIL shift_data rx=%b q=%b need 1011 0000", rx_data, q); end
    endtask

    task automatic test_rotate();
        int e, dc; logic [1:0] m; logic [3:0] dd;
        run_cmd(2'b00, 1'b0, 4'd0, 1'b0, 4'b1011, e, dc, m, dd);
        run_cmd(2'b10, 1'b0, 4'd4, 1'b0, 4'h0, e, dc, m, dd);
        checks++; if (e !== 4 || dc !== 5 || m !== 2'b01) begin
            errors++; $display("[TB] FAIL rotate_timing enbs=%0d done_cyc=%0d modo=%b need 4 5 01", e, dc, m); end
        checks++; if (rx_data !== 4'b1101 || q !== 4'b1011) begin
            errors++; $display("[TB] FAIL rotate_data rx=%b q=%b need 1101 1011", rx_data, q); end
    endtask

    task automatic test_overflow();
        int e, dc; logic [1:0] m; logic [3:0] dd;
        run_cmd(2'b00, 1'b0, 4'd0, 1'b0, 4'b1011, e, dc, m, dd);
        run_cmd(2'b01, 1'b1, 4'd6, 1'b0, 4'h0, e, dc, m, dd);
        checks++; if (e !== 6 || dc !== 7 || rx_data !== 4'b1100 || q !== 4'b0000) begin
            errors++; $display("[TB] FAIL overflow enbs=%0d done_cyc=%0d rx=%b q=%b need 6 7 1100 0000", e, dc, rx_data, q); end
    endtask

    task automatic test_nop();
        int e, dc; logic [1:0] m; logic [3:0] dd;
        run_cmd(2'b01, 1'b1, 4'd0, 1'b1, 4'h0, e, dc, m, dd);
        checks++; if (e !== 0 || dc !== 1 || rx_data !== 4'h0) begin
            errors++; $display("[TB] FAIL cnt0 enbs=%0d done_cyc=%0d rx=%b need 0 1 0000", e, dc, rx_data); end
        run_cmd(2'b10, 1'b1, 4'd3, 1'b0, 4'h0, e, dc, m, dd);
        run_cmd(2'b11, 1'b1, 4'd5, 1'b1, 4'hF, e, dc, m, dd);
        checks++; if (e !== 0 || dc !== 1 || rx_data !== 4'h0 || modo !== 2'b01) begin
            errors++; $display("[TB] FAIL op11 enbs=%0d done_cyc=%0d rx=%b modo=%b need 0 1 0000 01", e, dc, rx_data, modo); end
    endtask

    task automatic test_back_to_back();
        logic [6:1] rdy, dn, en;
        @(negedge clk);
        cmd_op = 2'b00; cmd_data = 4'b0101; cmd_valid = 1'b1;
        checks++; if (cmd_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_idle ready=%b need 1", cmd_ready); end
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            rdy[i] = cmd_ready; dn[i] = done; en[i] = enb;
        end
        cmd_valid = 1'b0;
        checks++; if (rdy !== 6'b100100 || dn !== 6'b010010 || en !== 6'b001001) begin
            errors++; $display("[TB] FAIL b2b ready=%b done=%b enb=%b need 100100 010010 001001", rdy, dn, en); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || q !== 4'b0101) begin
            errors++; $display("[TB] FAIL b2b_end busy=%b q=%b need 0 0101", busy, q); end
    endtask

`ifdef REGCTRL_ABORT_EN
    task automatic test_abort();
        int e, dc; logic [1:0] m; logic [3:0] dd;
        run_cmd(2'b00, 1'b0, 4'd0, 1'b0, 4'b1011, e, dc, m, dd);
        @(negedge clk);
        cmd_op = 2'b01; cmd_dir = 1'b1; cmd_cnt = 4'd10; cmd_fill = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        e = enb ? 1 : 0;
        @(negedge clk);
        e += enb ? 1 : 0;
        @(negedge clk);
        abort = 1'b1;
        #1;
        checks++; if (e !== 2 || enb !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_enb enbs=%0d enb=%b need 2 0", e, enb); end
        @(negedge clk);
        abort = 1'b0;
        checks++; if (done !== 1'b1 || aborted !== 1'b1 || q !== 4'b1100 || rx_data !== 4'b0010) begin
            errors++; $display("[TB] FAIL abort_done done=%b aborted=%b q=%b rx=%b need 1 1 1100 0010", done, aborted, q, rx_data); end
        run_cmd(2'b11, 1'b0, 4'd0, 1'b0, 4'h0, e, dc, m, dd);
        checks++; if (aborted !== 1'b0 || dc !== 1) begin
            errors++; $display("[TB] FAIL abort_clear aborted=%b done_cyc=%0d need 0 1", aborted, dc); end
    endtask
`endif

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dir = 1'b0;
        cmd_cnt = 4'd0; cmd_fill = 1'b0; cmd_data = 4'h0;
`ifdef REGCTRL_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_load();
        test_shift();
        test_rotate();
        test_overflow();
        test_nop();
        test_back_to_back();
`ifdef REGCTRL_ABORT_EN
        test_abort();
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
